// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + c_in, CHUNK bits per clock with a registered carry.
// start/busy/done handshake; sum, c_out and ovf update only on the completion edge.
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | adding one chunk per clock, idx = chunk being added
    // S_DONE | one-cycle result pulse; a new start is accepted here too
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_acc;
    logic              r_carry;
    logic              r_a_msb;
    logic              r_b_msb;
    logic [WIDTH-1:0]  r_sum;
    logic              r_c_out;
    logic              r_ovf;

    logic              w_accept;
    logic              w_last;
    logic [CHUNK:0]    w_chunk;
    logic [WIDTH-1:0]  w_chunk_ext;
    logic [WIDTH-1:0]  w_acc_next;

    assign w_accept = (r_state != S_RUN) && start;
    assign w_last   = (r_idx == LAST);

    // Operands shift right each RUN cycle so the active chunk always sits in the low bits;
    // the accumulator fills from the top so after NCHUNK steps it holds the full sum.
    assign w_chunk     = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
    assign w_chunk_ext = WIDTH'(w_chunk[CHUNK-1:0]) << (WIDTH - CHUNK);
    assign w_acc_next  = (r_acc >> CHUNK) | w_chunk_ext;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_carry <= c_in;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_idx   <= r_idx + 1'b1;
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_acc   <= w_acc_next;
            r_carry <= w_chunk[CHUNK];
            if (w_last) begin
                r_sum   <= w_acc_next;
                r_c_out <= w_chunk[CHUNK];
                r_ovf   <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign sum   = r_sum;
    assign c_out = r_c_out;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench for chunked_seq_adder: directed cases plus random ops checked against a plain-arithmetic model,
// on a 4-bit-chunk instance and a single-chunk (CHUNK=WIDTH) instance.
module tb_chunked_seq_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         start16 = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         busy, done, c_out, ovf;
    logic [W-1:0] sum;
    logic         busy16, done16, c_out16, ovf16;
    logic [W-1:0] sum16;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    chunked_seq_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    chunked_seq_adder #(.WIDTH(W), .CHUNK(W)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a), .b(b), .c_in(c_in),
        .busy(busy16), .done(done16), .sum(sum16), .c_out(c_out16), .ovf(ovf16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, c_out, sum} from the arithmetic definition
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        logic [W:0] s;
        logic       v;
        s = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        v = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
        return {v, s};
    endfunction

    // One operation on either instance; scramble changes inputs and pulses start while busy.
    task automatic do_op(input bit sel16, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input bit scramble);
        logic [W+1:0] exp;
        logic [W-1:0] held;
        int           lat;
        bit           got;
        int           want_lat;
        want_lat = sel16 ? 1 : 4;
        exp  = model(ia, ib, ic);
        @(negedge clk);
        held = sel16 ? sum16 : sum;
        a = ia; b = ib; c_in = ic;
        if (sel16) start16 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start16 = 1'b0;
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (sel16 ? done16 : done) begin
                got = 1;
                start = 1'b0;
            end else begin
                check("busy_in_run", sel16 ? busy16 : busy, 1'b1);
                check("sum_held", sel16 ? sum16 : sum, held);
                if (scramble) begin
                    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
                    start = (!sel16) && (lat < want_lat - 1) ? 1'($urandom) : 1'b0;
                end
            end
        end
        check("latency", lat, want_lat);
        check("busy_at_done", sel16 ? busy16 : busy, 1'b0);
        check("sum", sel16 ? sum16 : sum, exp[W-1:0]);
        check("c_out", sel16 ? c_out16 : c_out, exp[W]);
        check("ovf", sel16 ? ovf16 : ovf, exp[W+1]);
    endtask

    task automatic wait_done(output int t, output bit ok);
        int n;
        n = 0; ok = 0;
        while (!ok && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done) ok = 1;
        end
        t = cyc;
    endtask

    initial begin
        logic [W+1:0] e1, e2;
        int           t1, t2;
        bit           ok1, ok2;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_c_out", c_out, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        @(negedge clk); rst = 1'b0;

        do_op(0, 16'h0000, 16'h0001, 1'b0, 0);
        do_op(0, 16'hFFFF, 16'h0001, 1'b0, 0);
        do_op(0, 16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(0, 16'h0F0F, 16'h00F1, 1'b1, 0);
        do_op(0, 16'h8000, 16'h8000, 1'b0, 0);
        do_op(0, 16'h1234, 16'hABCD, 1'b1, 1);

        // start held high through DONE: back-to-back ops, done pulses NCHUNK+1 apart
        e1 = model(16'h4000, 16'h4000, 1'b0);
        e2 = model(16'hF00F, 16'h0FF1, 1'b1);
        @(negedge clk);
        a = 16'h4000; b = 16'h4000; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hF00F; b = 16'h0FF1; c_in = 1'b1;
        wait_done(t1, ok1);
        check("b2b_done1", ok1, 1'b1);
        check("b2b_sum1", sum, e1[W-1:0]);
        check("b2b_ovf1", ovf, e1[W+1]);
        wait_done(t2, ok2);
        start = 1'b0;
        check("b2b_done2", ok2, 1'b1);
        check("b2b_gap", t2 - t1, 5);
        check("b2b_sum2", sum, e2[W-1:0]);
        check("b2b_c_out2", c_out, e2[W]);
        @(posedge clk); #1;
        check("b2b_idle", busy | done, 1'b0);

        // reset in the middle of RUN discards the op and clears the result
        do_op(0, 16'h1111, 16'h2222, 1'b0, 0);
        @(negedge clk);
        a = 16'h5555; b = 16'h5555; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_sum", sum, '0);
        @(negedge clk); rst = 1'b0;
        do_op(0, 16'h5555, 16'h5555, 1'b0, 0);

        for (int i = 0; i < 40; i++)
            do_op(0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

        do_op(1, 16'h8000, 16'h8000, 1'b0, 0);
        do_op(1, 16'h7FFF, 16'h0001, 1'b0, 0);
        for (int i = 0; i < 10; i++)
            do_op(1, W'($urandom), W'($urandom), 1'($urandom), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
